// File: rtl/littlecpu_pkg.sv
// littlecpu_pkg: types shared by the littlecpu pipeline stages.
//   - Stage payload structs. A pipe_fifo between two stages takes its WIDTH
//     from $bits of the upstream stage's struct.
//   - PIPE_FIFO_DEPTH: the default buffer depth between stages.
//   - pipe_ptr_width(): pointer width, i.e. index bits plus one wrap bit.
package littlecpu_pkg;

  localparam int PIPE_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetcher_output;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [5:0]  op;
  } decoder_output;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] store_val;
    logic [2:0]  mem_op;
  } executor_output;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wb_val;
    logic        wb_en;
  } accessor_output;

  // The extra top bit separates the full case from the empty case when the
  // index bits of the two pointers are equal.
  function automatic int pipe_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pipe_fifo_ptr.sv
// pipe_fifo_ptr: wrapping read/write pointer for pipe_fifo.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   clear      : synchronous clear to 0 (flush)
//   inc        : advance the pointer by one
//   ptr        : {wrap bit, index}. The index wraps modulo DEPTH and the wrap
//                bit toggles on each wrap.
module pipe_fifo_ptr
  import littlecpu_pkg::*;
#(
  parameter int DEPTH = PIPE_FIFO_DEPTH,
  parameter int PW    = pipe_ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // DEPTH is a power of two, so the natural PW-bit rollover of ptr + 1 wraps
  // the index and toggles the wrap bit together.
  always_ff @(posedge clk) begin
    if (reset || clear) ptr <= '0;
    else if (inc)       ptr <= ptr + PW'(1);
  end

endmodule

// File: rtl/pipe_fifo.sv
// pipe_fifo: N-entry elastic buffer between littlecpu pipeline stages.
//   clk, reset     : clock, synchronous active-high reset
//   flush          : drop all held entries and any same-cycle push
//   input_valid/ready/data   : upstream handshake. input_ready comes from
//                              registers only.
//   output_valid/ready/data  : downstream handshake (head of queue)
//   count          : occupancy, 0..DEPTH
//   almost_full    : registered, count >= ALMOST_FULL
// With BYPASS=1, an empty buffer forwards input straight to the output in
// the same cycle. If the downstream takes it, nothing is stored.
module pipe_fifo
  import littlecpu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = PIPE_FIFO_DEPTH,
  parameter int ALMOST_FULL = DEPTH - 1,
  parameter int BYPASS      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     input_valid,
  output logic                     input_ready,
  input  logic [WIDTH-1:0]         input_data,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic [WIDTH-1:0]         output_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int PW = pipe_ptr_width(DEPTH);
  localparam int IW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             empty, full;
  logic             bypass, push, pop;
  logic [PW-1:0]    count_nxt;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[IW-1:0] == wr_ptr[IW-1:0]) && (rd_ptr[IW] != wr_ptr[IW]);

  // full depends only on the pointer registers, so output_ready has no
  // combinational path to input_ready. When full, a same-cycle pop cannot
  // make room for a push; input_ready rises on the next cycle.
  assign input_ready = !full;

  // Bypass: when empty, the downstream takes the input directly. No entry
  // is written and the count does not change.
  assign bypass = (BYPASS != 0) && empty && input_valid && output_ready && !flush;

  assign push = input_valid && input_ready && !flush && !bypass;
  assign pop  = !empty && output_ready;

  always_comb begin
    output_valid = !empty;
    output_data  = mem[rd_ptr[IW-1:0]];
    if ((BYPASS != 0) && empty) begin
      output_valid = input_valid && !flush;
      output_data  = input_data;
    end
  end

  pipe_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  pipe_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // The storage array has no reset. Stale entries are never visible
  // because output_valid is driven from the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IW-1:0]] <= input_data;
  end

  // count and almost_full are kept in their own registers so that both
  // come straight from flops. almost_full is updated in the same cycle as
  // count.
  always_comb begin
    count_nxt = count;
    if (flush)             count_nxt = '0;
    else if (push && !pop) count_nxt = count + PW'(1);
    else if (pop && !push) count_nxt = count - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_nxt;
      almost_full <= (count_nxt >= PW'(ALMOST_FULL));
    end
  end

`ifdef RISCV_FORMAL
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full));
      assert (!(pop && empty));
      assert (count == PW'(wr_ptr - rd_ptr));
    end
  end

  assert property (@(posedge clk) disable iff (reset)
    (output_valid && !output_ready && !flush) |=> (flush || $stable(output_data)));
`endif

endmodule

// File: tb/tb_pipe_fifo.sv
module tb_pipe_fifo;

  logic       clk = 1'b0;
  logic       reset;

  logic       a_flush, a_iv, a_ir, a_ov, a_or, a_af;
  logic [7:0] a_id, a_od;
  logic [2:0] a_cnt;

  logic       b_flush, b_iv, b_ir, b_ov, b_or, b_af;
  logic [7:0] b_id, b_od;
  logic [2:0] b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_fifo #(.WIDTH(8), .DEPTH(4), .ALMOST_FULL(3), .BYPASS(0)) dut (
    .clk(clk), .reset(reset), .flush(a_flush),
    .input_valid(a_iv), .input_ready(a_ir), .input_data(a_id),
    .output_valid(a_ov), .output_ready(a_or), .output_data(a_od),
    .count(a_cnt), .almost_full(a_af)
  );

  pipe_fifo #(.WIDTH(8), .DEPTH(4), .ALMOST_FULL(3), .BYPASS(1)) dut_bp (
    .clk(clk), .reset(reset), .flush(b_flush),
    .input_valid(b_iv), .input_ready(b_ir), .input_data(b_id),
    .output_valid(b_ov), .output_ready(b_or), .output_data(b_od),
    .count(b_cnt), .almost_full(b_af)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_flush = 0; a_iv = 0; a_id = 0; a_or = 0;
    b_flush = 0; b_iv = 0; b_id = 0; b_or = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_cnt !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_cnt); end
    checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%b exp=0", a_ov); end
    checks++; if (a_ir !== 1'b1) begin failures++; $display("FAIL reset_iready got=%b exp=1", a_ir); end
    checks++; if (a_af !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", a_af); end
    a_iv = 1; a_id = 8'hA1;
    @(negedge clk);
    a_iv = 0;
    checks++; if (a_ov !== 1'b1 || a_od !== 8'hA1) begin failures++; $display("FAIL first_push got=%b/%h exp=1/a1", a_ov, a_od); end
  endtask

  task automatic test_fill();
    do_reset();
    a_or = 0;
    for (int i = 1; i <= 4; i++) begin
      a_iv = 1; a_id = 8'(i);
      @(negedge clk);
      checks++;
      if (a_cnt !== 3'(i) || a_af !== (i >= 3) || a_ir !== (i < 4)) begin
        failures++; $display("FAIL fill_%0d got=cnt%0d af%b ir%b exp=cnt%0d af%b ir%b", i, a_cnt, a_af, a_ir, i, i >= 3, i < 4);
      end
    end
    a_iv = 1; a_id = 8'h05;
    @(negedge clk);
    checks++; if (a_cnt !== 3'd4 || a_ir !== 1'b0) begin failures++; $display("FAIL full_hold got=cnt%0d ir%b exp=cnt4 ir0", a_cnt, a_ir); end
    a_or = 1;
    checks++; if (a_ov !== 1'b1 || a_od !== 8'h01) begin failures++; $display("FAIL drain_head got=%b/%h exp=1/01", a_ov, a_od); end
    @(negedge clk);
    checks++; if (a_od !== 8'h02 || a_ir !== 1'b1 || a_cnt !== 3'd3) begin failures++; $display("FAIL after_pop1 got=%h ir%b cnt%0d exp=02 ir1 cnt3", a_od, a_ir, a_cnt); end
    @(negedge clk);
    a_iv = 0;
    checks++; if (a_od !== 8'h03 || a_cnt !== 3'd3) begin failures++; $display("FAIL refill got=%h cnt%0d exp=03 cnt3", a_od, a_cnt); end
    for (int i = 4; i <= 5; i++) begin
      @(negedge clk);
      checks++; if (a_ov !== 1'b1 || a_od !== 8'(i)) begin failures++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, a_ov, a_od, 8'(i)); end
    end
    @(negedge clk);
    checks++; if (a_ov !== 1'b0 || a_cnt !== 3'd0) begin failures++; $display("FAIL drained got=%b cnt%0d exp=0 cnt0", a_ov, a_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_or = 1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (a_ov !== 1'b1 || a_od !== 8'(i - 1) || a_cnt !== 3'd1 || a_ir !== 1'b1) begin
          failures++; $display("FAIL stream_%0d got=%b/%h cnt%0d exp=1/%h cnt1", i - 1, a_ov, a_od, a_cnt, 8'(i - 1));
        end
      end
      a_iv = (i < 16); a_id = 8'(i);
    end
    @(negedge clk);
    checks++; if (a_ov !== 1'b0 || a_cnt !== 3'd0) begin failures++; $display("FAIL stream_end got=%b cnt%0d exp=0 cnt0", a_ov, a_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    a_or = 0;
    for (int i = 1; i <= 3; i++) begin
      a_iv = 1; a_id = 8'(i);
      @(negedge clk);
    end
    a_flush = 1; a_iv = 1; a_id = 8'hEE; a_or = 1;
    checks++; if (a_ov !== 1'b1 || a_od !== 8'h01 || a_cnt !== 3'd3) begin failures++; $display("FAIL flush_head got=%b/%h cnt%0d exp=1/01 cnt3", a_ov, a_od, a_cnt); end
    @(negedge clk);
    a_flush = 0; a_iv = 0;
    checks++; if (a_cnt !== 3'd0 || a_ov !== 1'b0 || a_ir !== 1'b1 || a_af !== 1'b0) begin
      failures++; $display("FAIL flush_after got=cnt%0d ov%b ir%b af%b exp=cnt0 ov0 ir1 af0", a_cnt, a_ov, a_ir, a_af);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL flush_ghost got=%b/%h exp=0", a_ov, a_od); end
    end
  endtask

  task automatic test_bypass();
    do_reset();
    b_iv = 1; b_id = 8'h5A; b_or = 1;
    #1;
    checks++; if (b_ov !== 1'b1 || b_od !== 8'h5A || b_cnt !== 3'd0) begin failures++; $display("FAIL bypass_pass got=%b/%h cnt%0d exp=1/5a cnt0", b_ov, b_od, b_cnt); end
    @(negedge clk);
    b_iv = 0;
    #1;
    checks++; if (b_ov !== 1'b0 || b_cnt !== 3'd0) begin failures++; $display("FAIL bypass_nostore got=%b cnt%0d exp=0 cnt0", b_ov, b_cnt); end
    @(negedge clk);
    b_iv = 1; b_id = 8'h5A; b_or = 0;
    #1;
    checks++; if (b_ov !== 1'b1 || b_od !== 8'h5A) begin failures++; $display("FAIL bypass_comb got=%b/%h exp=1/5a", b_ov, b_od); end
    @(negedge clk);
    b_iv = 0;
    #1;
    checks++; if (b_cnt !== 3'd1 || b_ov !== 1'b1 || b_od !== 8'h5A) begin failures++; $display("FAIL bypass_store got=cnt%0d %b/%h exp=cnt1 1/5a", b_cnt, b_ov, b_od); end
    @(negedge clk);
    b_or = 1;
    @(negedge clk);
    b_flush = 1; b_iv = 1; b_id = 8'h33;
    #1;
    checks++; if (b_ov !== 1'b0 || b_cnt !== 3'd0) begin failures++; $display("FAIL bypass_flush got=%b cnt%0d exp=0 cnt0", b_ov, b_cnt); end
    @(negedge clk);
    b_flush = 0; b_iv = 0; b_or = 0;
    #1;
    checks++; if (b_ov !== 1'b0 || b_cnt !== 3'd0) begin failures++; $display("FAIL bypass_flush_after got=%b cnt%0d exp=0 cnt0", b_ov, b_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int   errs = 0;
    logic do_push, do_pop;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      checks++;
      if (a_cnt !== 3'(q.size()) || a_ov !== (q.size() > 0) || a_ir !== (q.size() < 4) ||
          a_af !== (q.size() >= 3) || (q.size() > 0 && a_od !== q[0])) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL random_c%0d got=cnt%0d ov%b ir%b af%b d%h exp=cnt%0d head%h",
                                cyc, a_cnt, a_ov, a_ir, a_af, a_od, q.size(), (q.size() > 0) ? q[0] : 8'h00);
      end
      a_iv = ($urandom_range(0, 3) != 0);
      a_id = 8'($urandom);
      a_or = ($urandom_range(0, 2) != 0);
      do_pop  = (q.size() > 0) && a_or;
      do_push = a_iv && (q.size() < 4);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(a_id);
    end
    @(negedge clk);
    reset = 1; a_iv = 1; a_or = 0;
    @(negedge clk);
    reset = 0; a_iv = 0;
    checks++; if (a_cnt !== 3'd0 || a_ov !== 1'b0 || a_ir !== 1'b1) begin failures++; $display("FAIL midreset got=cnt%0d ov%b ir%b exp=cnt0 ov0 ir1", a_cnt, a_ov, a_ir); end
  endtask

  initial begin
    reset = 1;
    a_flush = 0; a_iv = 0; a_id = 0; a_or = 0;
    b_flush = 0; b_iv = 0; b_id = 0; b_or = 0;
    test_reset();
    test_fill();
    test_back_to_back();
    test_flush();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
